// File: rtl/reduce_debounce.sv
// reduce_debounce
// Synchronizes a raw switch vector, debounces it as a whole, and publishes
// registered AND/OR/XOR/NOR reductions of the accepted value. A one-cycle
// update strobe marks every change of the reduction outputs. A counter tracks
// how many commits flipped the XOR parity of the accepted vector. The hold
// input freezes only the reduction outputs; debouncing and parity counting
// keep running underneath so the outputs can resync when hold is released.

module reduce_debounce #(
  parameter int W     = 8,
  parameter int DEB   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sw,
  input  logic             hold,
  output logic [3:0]       led,
  output logic             upd,
  output logic [CNT_W-1:0] par_cnt
);

  // Stability counter is at least one bit wide so DEB = 1 still elaborates.
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

  // Reduction packing: [3] NOR, [2] XOR, [1] OR, [0] AND.
  function automatic logic [3:0] reduce_vec(input logic [W-1:0] v);
    return {~|v, ^v, |v, &v};
  endfunction

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [W-1:0]  cand;
  logic [W-1:0]  db;
  logic [CW-1:0] cnt;

  logic          commit;
  logic          par_flip;
  logic [W-1:0]  led_src;
  logic [3:0]    led_nxt;

  // Commit decode; the outputs look at the candidate in the commit cycle so
  // the reductions update on the same edge that db does.
  always_comb begin
    commit   = 1'b0;
    par_flip = 1'b0;
    led_src  = db;
    if ((s2 == cand) && (cnt == CNT_MAX) && (cand != db)) begin
      commit  = 1'b1;
      led_src = cand;
    end
    par_flip = commit && ((^cand) != (^db));
    led_nxt  = reduce_vec(led_src);
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Debounce: any change restarts the stability count; a stable candidate
  // that differs from the accepted value is committed once the count
  // reaches DEB-1. The count then saturates until the input moves again.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
      db   <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (commit) begin
      db <= cand;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Parity-change counter, wraps naturally; runs regardless of hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_cnt <= '0;
    end else if (par_flip) begin
      par_cnt <= par_cnt + CNT_W'(1);
    end
  end

  // Reduction outputs and update strobe; hold freezes led and masks upd.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 4'b1000;
      upd <= 1'b0;
    end else if (hold) begin
      upd <= 1'b0;
    end else begin
      led <= led_nxt;
      upd <= (led_nxt != led);
    end
  end

endmodule

// File: tb/tb_reduce_debounce.sv
// Directed bench for reduce_debounce with W=8, DEB=4, CNT_W=4.
module tb_reduce_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       hold;
  logic [3:0] led;
  logic       upd;
  logic [3:0] par_cnt;

  int checks = 0;
  int errors = 0;

  reduce_debounce #(.W(8), .DEB(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .hold    (hold),
    .led     (led),
    .upd     (upd),
    .par_cnt (par_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    hold = 1'b0;
    sw   = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (led !== 4'b1000) begin errors++; $display("FAIL reset_led got %b want %b", led, 4'b1000); end
    checks++;
    if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd); end
    checks++;
    if (par_cnt !== 4'd0) begin errors++; $display("FAIL reset_par got %0d want 0", par_cnt); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (led !== 4'b1000 || upd !== 1'b0 || par_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got led=%b upd=%b par=%0d want led=1000 upd=0 par=0", i, led, upd, par_cnt);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    sw = 8'hFF;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (led !== 4'b1000 || upd !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge %0d got led=%b upd=%b want led=1000 upd=0", e, led, upd);
      end
    end
    tick();
    checks++;
    if (led !== 4'b0011 || upd !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge7 got led=%b upd=%b want led=0011 upd=1", led, upd);
    end
    checks++;
    if (par_cnt !== 4'd0) begin errors++; $display("FAIL latency_par got %0d want 0", par_cnt); end
    tick();
    checks++;
    if (led !== 4'b0011 || upd !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge8 got led=%b upd=%b want led=0011 upd=0", led, upd);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sw = 8'h01;
    tick(); tick(); tick();
    sw = 8'h00;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (led !== 4'b1000 || upd !== 1'b0 || par_cnt !== 4'd0) begin
        errors++;
        $display("FAIL glitch cyc %0d got led=%b upd=%b par=%0d want led=1000 upd=0 par=0", i, led, upd, par_cnt);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    sw   = 8'h07;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (led !== 4'b1000 || upd !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen cyc %0d got led=%b upd=%b want led=1000 upd=0", i, led, upd);
      end
    end
    checks++;
    if (par_cnt !== 4'd1) begin errors++; $display("FAIL hold_par got %0d want 1", par_cnt); end
    hold = 1'b0;
    tick();
    checks++;
    if (led !== 4'b0110 || upd !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got led=%b upd=%b want led=0110 upd=1", led, upd);
    end
    tick();
    checks++;
    if (led !== 4'b0110 || upd !== 1'b0) begin
      errors++;
      $display("FAIL hold_after got led=%b upd=%b want led=0110 upd=0", led, upd);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] vec  [4];
    logic [3:0] lexp [4];
    logic [3:0] pexp [4];
    vec[0] = 8'h80; lexp[0] = 4'b0110; pexp[0] = 4'd1;
    vec[1] = 8'hFF; lexp[1] = 4'b0011; pexp[1] = 4'd2;
    vec[2] = 8'h0F; lexp[2] = 4'b0010; pexp[2] = 4'd2;
    vec[3] = 8'h00; lexp[3] = 4'b1000; pexp[3] = 4'd2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sw = vec[k];
      for (int e = 1; e <= 6; e++) tick();
      tick();
      checks++;
      if (led !== lexp[k] || upd !== 1'b1 || par_cnt !== pexp[k]) begin
        errors++;
        $display("FAIL pattern sw=%h got led=%b upd=%b par=%0d want led=%b upd=1 par=%0d",
                 vec[k], led, upd, par_cnt, lexp[k], pexp[k]);
      end
      tick();
      checks++;
      if (upd !== 1'b0) begin errors++; $display("FAIL pattern_pulse sw=%h got upd=%b want 0", vec[k], upd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pe;
    logic [3:0] le;
    do_reset();
    pe = 4'd0;
    for (int i = 0; i < 17; i++) begin
      sw = (i % 2 == 0) ? 8'h01 : 8'h00;
      le = (i % 2 == 0) ? 4'b0110 : 4'b1000;
      pe = pe + 4'd1;
      for (int e = 0; e < 8; e++) tick();
      checks++;
      if (par_cnt !== pe || led !== le) begin
        errors++;
        $display("FAIL wrap commit %0d got par=%0d led=%b want par=%0d led=%b", i, par_cnt, led, pe, le);
      end
    end
    checks++;
    if (par_cnt !== 4'd1) begin errors++; $display("FAIL wrap_final got %0d want 1", par_cnt); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    sw = 8'hFF;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (led !== 4'b1000 || upd !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_early edge %0d got led=%b upd=%b want led=1000 upd=0", e, led, upd);
      end
    end
    tick();
    checks++;
    if (led !== 4'b0011 || upd !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_edge7 got led=%b upd=%b want led=0011 upd=1", led, upd);
    end
  endtask

  task automatic test_rst_override();
    do_reset();
    sw = 8'h80;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (led !== 4'b0110 || par_cnt !== 4'd1) begin
      errors++;
      $display("FAIL override_pre got led=%b par=%0d want led=0110 par=1", led, par_cnt);
    end
    hold = 1'b1;
    rst  = 1'b1;
    tick();
    checks++;
    if (led !== 4'b1000 || upd !== 1'b0 || par_cnt !== 4'd0) begin
      errors++;
      $display("FAIL override got led=%b upd=%b par=%0d want led=1000 upd=0 par=0", led, upd, par_cnt);
    end
    rst  = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    sw   = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_hold();
    test_patterns();
    test_back_to_back();
    test_rst_mid();
    test_rst_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_debounce.md
REDUCE_DEBOUNCE -- requirements
Module: reduce_debounce

Interface
REQ-001 Parameter W, default 8, width of the switch vector; legal range W >= 1.
REQ-002 Parameter DEB, default 4, consecutive stable cycles required before a new switch value is accepted; legal range DEB >= 1.
REQ-003 Parameter CNT_W, default 8, width of the parity-change counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sw  input  W  raw, asynchronous switch vector.
REQ-007 hold  input  1  synchronous; when high, led is frozen.
REQ-008 led  output  4  registered reductions of the accepted vector: [0] AND, [1] OR, [2] XOR, [3] NOR.
REQ-009 upd  output  1  registered one-cycle pulse; high in every cycle in which led took a new value at the preceding edge.
REQ-010 par_cnt  output  CNT_W  registered count of accepted-vector XOR-parity changes.

Function
REQ-011 sw SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Debounce state SHALL be candidate cand[W], counter cnt (width clog2(DEB), min 1) and accepted vector db[W].
REQ-013 At each edge, if s2 != cand: cand <= s2 and cnt <= 0, with no commit.
REQ-014 Otherwise, if cnt == DEB-1 and cand != db, a commit SHALL occur: db <= cand.
REQ-015 Otherwise, if cnt < DEB-1: cnt increments; at DEB-1 the counter saturates.
REQ-016 A change in s2 that lasts fewer than DEB cycles, then returns to db, SHALL NOT commit.
REQ-017 Next led value SHALL be R(v) = {~|v, ^v, |v, &v}, where v = cand in a commit cycle and v = db otherwise.
REQ-018 When hold = 0: led <= R(v) at every edge. When hold = 1: led keeps its value.
REQ-019 upd <= 1 exactly when hold = 0 and R(v) != current led; otherwise upd <= 0.
REQ-020 Commits and db updates SHALL continue while hold = 1.
REQ-021 When hold falls, led SHALL resync to R(db) at the next edge, and upd pulses if the value differs.
REQ-022 On a commit where ^cand != ^db, par_cnt SHALL increment by 1 modulo 2^CNT_W (wrap to 0), independent of hold.
REQ-023 Latency: with sw stable from before edge 1, led and upd change at edge DEB+3 (edge 7 for DEB=4), given hold = 0.
REQ-024 With W = 1, led[0] == led[1] == sw value and led[2] == sw value; no special-casing.

Reset
REQ-025 When rst = 1 at an edge, s1, s2, cand, db, cnt SHALL all go to 0 and par_cnt to 0.
REQ-026 Reset SHALL set led to 4'b1000 (R(0)) and upd to 0.
REQ-027 rst SHALL override hold and any commit in progress in the same cycle.
REQ-028 After rst deasserts, an in-flight debounce SHALL restart from cnt = 0.

Verification (W=8, DEB=4, CNT_W=4)
REQ-029 Reset, sw = 0x00, hold = 0 -> led = 4'b1000, upd = 0, par_cnt = 0, unchanged for 20 cycles.
REQ-030 sw = 0xFF from before edge 1 -> at edge 7, led = 4'b0011 and upd = 1 for one cycle; par_cnt = 0 (parity unchanged).
REQ-031 From 0x00, sw = 0x01 held for 3 cycles then back to 0x00 -> no led change, upd stays 0, par_cnt = 0.
REQ-032 hold = 1, then sw 0x00 -> 0x07 -> led stays 4'b1000 and par_cnt = 1; hold released -> led = 4'b0110 at the next edge, upd = 1 for one cycle.
REQ-033 Seventeen alternating commits of 0x01 and 0x00 -> par_cnt wraps 15 -> 0 and ends at 1.
REQ-034 rst asserted 2 cycles into a debounce of 0xFF, then released with sw held -> first led change at edge 7 after release, led = 4'b0011.
